mult_div_ctrl: RTL and testbench

- Multicycle sequencer for the CPU's signed multiply and divide (mult/div); the control unit hands off to it and stalls until it finishes.
- Multiply uses a radix-2 Booth datapath. Divide uses restoring division on magnitudes, followed by a sign fix-up.
- Outputs feed the Hi/Lo select muxes (hi_sel/lo_sel: 0 = div result, 1 = mult result) and the Hi/Lo register write enables.
- The control unit waits on `busy` and branches to the exception path on `div_zero`.

---
 rtl/mult_div_ctrl_if.sv | 28 ++
 rtl/mult_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_mult_div_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_ctrl_if.sv
// rtl/mult_div_ctrl_if.sv - handshake and result bus between control unit and mult/div sequencer
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             hi_sel;
    logic             lo_sel;
    logic             hi_write;
    logic             lo_write;

    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, div_zero, hi_out, lo_out, hi_sel, lo_sel, hi_write, lo_write
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, div_zero, hi_out, lo_out, hi_sel, lo_sel, hi_write, lo_write
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - multicycle signed Booth multiply / restoring divide sequencer
module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    // acc is one bit wider so that subtracting the most negative multiplicand cannot overflow;
    // in divide it holds the partial remainder and mcand holds |b|
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     mcand;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;
    logic               op_mult;
    logic               sign_q;
    logic               sign_r;

    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   quo_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    always_comb begin
        booth_sum = acc;
        if ({q[0], q_m1} == 2'b01) begin
            booth_sum = acc + mcand;
        end else if ({q[0], q_m1} == 2'b10) begin
            booth_sum = acc - mcand;
        end
        rem_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
        quo_sh = {q[WIDTH-2:0], 1'b0};
        trial  = rem_sh - mcand;
        a_abs  = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_abs  = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            acc          <= '0;
            mcand        <= '0;
            q            <= '0;
            q_m1         <= 1'b0;
            cnt          <= '0;
            op_mult      <= 1'b0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi_out   <= '0;
            bus.lo_out   <= '0;
            bus.hi_sel   <= 1'b0;
            bus.lo_sel   <= 1'b0;
            bus.hi_write <= 1'b0;
            bus.lo_write <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi_write <= 1'b0;
            bus.lo_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_mult) begin
                        mcand    <= {bus.a[WIDTH-1], bus.a};
                        q        <= bus.b;
                        acc      <= '0;
                        q_m1     <= 1'b0;
                        cnt      <= CNT_W'(WIDTH);
                        op_mult  <= 1'b1;
                        bus.busy <= 1'b1;
                        state    <= S_MULT;
                    end else if (bus.start_div) begin
                        bus.busy <= 1'b1;
                        if (bus.b == '0) begin
                            state <= S_ERR;
                        end else begin
                            acc     <= '0;
                            q       <= a_abs;
                            mcand   <= {1'b0, b_abs};
                            sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            sign_r  <= bus.a[WIDTH-1];
                            cnt     <= CNT_W'(WIDTH);
                            op_mult <= 1'b0;
                            state   <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (!trial[WIDTH]) begin
                        acc <= trial;
                        q   <= quo_sh | WIDTH'(1);
                    end else begin
                        acc <= rem_sh;
                        q   <= quo_sh;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (sign_q) begin
                        q <= -q;
                    end
                    if (sign_r) begin
                        acc <= -acc;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    bus.hi_out   <= acc[WIDTH-1:0];
                    bus.lo_out   <= q;
                    bus.done     <= 1'b1;
                    bus.hi_write <= 1'b1;
                    bus.lo_write <= 1'b1;
                    bus.hi_sel   <= op_mult;
                    bus.lo_sel   <= op_mult;
                    bus.busy     <= 1'b0;
                    state        <= S_IDLE;
                end
                S_ERR: begin
                    bus.div_zero <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - directed self-checking bench for mult_div_ctrl
module tb_mult_div_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int   done_cnt;
    int   done_k;
    int   dz_cnt;
    int   dz_k;
    int   wr_cnt;
    int   busy_err;

    mult_div_ctrl_if #(.WIDTH(32)) bif ();

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bif.start_mult = m;
        bif.start_div  = d;
        bif.a          = av;
        bif.b          = bv;
        @(posedge clk);
        #1;
        bif.start_mult = 1'b0;
        bif.start_div  = 1'b0;
    endtask

    // Samples limit cycles after the accepting edge; busy is expected high for k < exp_end.
    task automatic watch(input int limit, input int exp_end, input int pulse_k);
        done_cnt = 0; done_k = -1; dz_cnt = 0; dz_k = -1; wr_cnt = 0; busy_err = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (bif.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bif.div_zero) begin
                dz_cnt++;
                if (dz_k < 0) dz_k = k;
            end
            if (bif.hi_write || bif.lo_write) wr_cnt++;
            if (bif.busy !== (k < exp_end)) busy_err++;
            bif.start_div = (k == pulse_k);
        end
        bif.start_div = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bif.start_mult = 1'b0;
        bif.start_div  = 1'b0;
        bif.a = '0;
        bif.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bif.busy, 0);
        check("rst_done", bif.done, 0);
        check("rst_hi", bif.hi_out, 0);
        check("rst_lo", bif.lo_out, 0);
        check("rst_sel", {bif.hi_sel, bif.lo_sel, bif.hi_write, bif.lo_write, bif.div_zero}, 0);
        reset = 1'b0;

        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        watch(36, 33, 0);
        check("m1_lat", done_k, 33);
        check("m1_done_cnt", done_cnt, 1);
        check("m1_wr_cnt", wr_cnt, 1);
        check("m1_busy", busy_err, 0);
        check("m1_hi", bif.hi_out, 32'hFFFF_FFFF);
        check("m1_lo", bif.lo_out, 32'hFFFF_FFEB);
        check("m1_sel", {bif.hi_sel, bif.lo_sel}, 2'b11);

        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        watch(35, 33, 0);
        check("m2_lat", done_k, 33);
        check("m2_hi", bif.hi_out, 32'h4000_0000);
        check("m2_lo", bif.lo_out, 32'h0000_0000);

        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        watch(36, 34, 0);
        check("d1_lat", done_k, 34);
        check("d1_wr_cnt", wr_cnt, 1);
        check("d1_busy", busy_err, 0);
        check("d1_lo", bif.lo_out, 32'hFFFF_FFFD);
        check("d1_hi", bif.hi_out, 32'hFFFF_FFFF);
        check("d1_sel", {bif.hi_sel, bif.lo_sel}, 2'b00);

        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(35, 34, 0);
        check("d_ovf_lo", bif.lo_out, 32'h8000_0000);
        check("d_ovf_hi", bif.hi_out, 32'h0000_0000);

        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        watch(35, 34, 0);
        check("d2_lo", bif.lo_out, 32'd14);
        check("d2_hi", bif.hi_out, 32'd2);

        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        watch(4, 1, 0);
        check("dz_k", dz_k, 1);
        check("dz_cnt", dz_cnt, 1);
        check("dz_done_cnt", done_cnt, 0);
        check("dz_wr_cnt", wr_cnt, 0);
        check("dz_busy", busy_err, 0);
        check("dz_hi_keep", bif.hi_out, 32'd2);
        check("dz_lo_keep", bif.lo_out, 32'd14);
        check("dz_sel_keep", {bif.hi_sel, bif.lo_sel}, 2'b00);

        start_op(1'b1, 1'b1, 32'd3, 32'd4);
        watch(40, 33, 10);
        check("both_lat", done_k, 33);
        check("both_done_cnt", done_cnt, 1);
        check("both_dz_cnt", dz_cnt, 0);
        check("both_busy", busy_err, 0);
        check("both_lo", bif.lo_out, 32'd12);
        check("both_hi", bif.hi_out, 32'd0);
        check("both_sel", {bif.hi_sel, bif.lo_sel}, 2'b11);

        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        watch(10, 1000, 0);
        check("rd_busy_mid", busy_err, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rd_busy", bif.busy, 0);
        check("rd_wr", {bif.done, bif.hi_write, bif.lo_write, bif.div_zero}, 0);
        check("rd_hi", bif.hi_out, 0);
        check("rd_lo", bif.lo_out, 0);
        check("rd_sel", {bif.hi_sel, bif.lo_sel}, 0);
        reset = 1'b0;

        start_op(1'b1, 1'b0, 32'd6, 32'd6);
        watch(35, 33, 0);
        check("m3_lat", done_k, 33);
        check("m3_lo", bif.lo_out, 32'd36);
        check("m3_hi", bif.hi_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
